// File: rtl/tile_addr_pkg.sv
// rtl/tile_addr_pkg.sv - shared types and helpers for the tile burst generator
package tile_addr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    EMIT
  } state_t;

  localparam int DEFAULT_MAX_BURST_BYTES = 256;

  // Unsigned minimum on a wide common type; callers cast in and out.
  function automatic logic [63:0] umin(input logic [63:0] a, input logic [63:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tile_burst_gen_if.sv
// rtl/tile_burst_gen_if.sv - tile request and burst descriptor handshake bundle
interface tile_burst_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16,
  parameter int LEN_WIDTH  = 16
);

  logic                  req_valid;
  logic                  req_ready;
  logic [DIM_WIDTH-1:0]  req_row_start;
  logic [DIM_WIDTH-1:0]  req_col_start;
  logic [DIM_WIDTH-1:0]  req_rows;
  logic [DIM_WIDTH-1:0]  req_cols;
  logic [DIM_WIDTH-1:0]  req_halo;
  logic                  req_is_reference;

  logic                  burst_valid;
  logic                  burst_ready;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  burst_last;

  modport master (
    output req_valid, req_row_start, req_col_start, req_rows, req_cols,
           req_halo, req_is_reference, burst_ready,
    input  req_ready, burst_valid, burst_addr, burst_len, burst_last
  );

  modport slave (
    input  req_valid, req_row_start, req_col_start, req_rows, req_cols,
           req_halo, req_is_reference, burst_ready,
    output req_ready, burst_valid, burst_addr, burst_len, burst_last
  );

endinterface

// File: rtl/tile_window_clamp.sv
// rtl/tile_window_clamp.sv - halo expansion and frame-edge clamp of a tile window
module tile_window_clamp
  import tile_addr_pkg::*;
#(
  parameter int DIM_WIDTH = 16
) (
  input  logic [DIM_WIDTH-1:0] row_start,
  input  logic [DIM_WIDTH-1:0] col_start,
  input  logic [DIM_WIDTH-1:0] rows,
  input  logic [DIM_WIDTH-1:0] cols,
  input  logic [DIM_WIDTH-1:0] halo,
  input  logic                 is_reference,
  input  logic [DIM_WIDTH-1:0] frame_width,
  input  logic [DIM_WIDTH-1:0] frame_height,
  output logic [DIM_WIDTH:0]   r0,
  output logic [DIM_WIDTH:0]   r1,
  output logic [DIM_WIDTH:0]   c0,
  output logic [DIM_WIDTH:0]   c1,
  output logic                 empty
);

  // Far-edge sums add three DIM_WIDTH terms, so they get two extra bits.
  localparam int SW = DIM_WIDTH + 2;

  logic [DIM_WIDTH-1:0] h;
  logic [SW-1:0]        row_end;
  logic [SW-1:0]        col_end;

  always_comb begin
    h       = is_reference ? halo : '0;
    r0      = (row_start >= h) ? {1'b0, row_start - h} : '0;
    c0      = (col_start >= h) ? {1'b0, col_start - h} : '0;
    row_end = SW'(row_start) + SW'(rows) + SW'(h);
    col_end = SW'(col_start) + SW'(cols) + SW'(h);
    r1      = (DIM_WIDTH+1)'(umin(64'(row_end), 64'(frame_height)));
    c1      = (DIM_WIDTH+1)'(umin(64'(col_end), 64'(frame_width)));
    empty   = (r1 <= r0) || (c1 <= c0);
  end

endmodule

// File: rtl/tile_burst_gen.sv
// rtl/tile_burst_gen.sv - tile request to per-row DMA burst descriptor stream
// BURST_ALIGN_SPLIT_EN: when defined, no burst crosses a MAX_BURST_BYTES boundary.
module tile_burst_gen
  import tile_addr_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DIM_WIDTH       = 16,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_BURST_BYTES = DEFAULT_MAX_BURST_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] frame_base_addr,
  input  logic [DIM_WIDTH-1:0]  frame_stride_bytes,
  input  logic [DIM_WIDTH-1:0]  bytes_per_pixel,
  input  logic [DIM_WIDTH-1:0]  frame_width,
  input  logic [DIM_WIDTH-1:0]  frame_height,
  tile_burst_gen_if.slave       bus,
  output logic                  busy
);

`ifdef BURST_ALIGN_SPLIT_EN
  localparam logic ALIGN_SPLIT = 1'b1;
`else
  localparam logic ALIGN_SPLIT = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] MAX_BYTES  = ADDR_WIDTH'(MAX_BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(MAX_BURST_BYTES - 1);
  localparam logic [DIM_WIDTH:0]    ONE_ROW    = (DIM_WIDTH+1)'(1);

  state_t               state;
  logic [DIM_WIDTH-1:0] row_start_q, col_start_q, rows_q, cols_q, halo_q;
  logic                 is_ref_q;

  logic [ADDR_WIDTH-1:0] row_addr;
  logic [ADDR_WIDTH-1:0] row_bytes;
  logic [ADDR_WIDTH-1:0] remain;
  logic [DIM_WIDTH:0]    rows_left;

  logic [DIM_WIDTH:0]    r0, r1, c0, c1;
  logic                  win_empty;

  logic [ADDR_WIDTH-1:0] win_addr, win_bytes;
  logic [DIM_WIDTH:0]    win_rows;
  logic                  step_in_row;
  logic [ADDR_WIDTH-1:0] nxt_row_addr, nxt_addr, nxt_remain;
  logic [DIM_WIDTH:0]    nxt_rows_left;

  tile_window_clamp #(.DIM_WIDTH(DIM_WIDTH)) u_clamp (
    .row_start    (row_start_q),
    .col_start    (col_start_q),
    .rows         (rows_q),
    .cols         (cols_q),
    .halo         (halo_q),
    .is_reference (is_ref_q),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .r0           (r0),
    .r1           (r1),
    .c0           (c0),
    .c1           (c1),
    .empty        (win_empty)
  );

  // Bytes available before the burst must stop at address a.
  function automatic logic [ADDR_WIDTH-1:0] span_limit(input logic [ADDR_WIDTH-1:0] a);
    return MAX_BYTES - (ALIGN_SPLIT ? (a & ALIGN_MASK) : '0);
  endfunction

  function automatic logic [LEN_WIDTH-1:0] burst_len_of(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [ADDR_WIDTH-1:0] rem);
    return LEN_WIDTH'(umin(64'(rem), 64'(span_limit(a))));
  endfunction

  function automatic logic burst_last_of(input logic [ADDR_WIDTH-1:0] a,
                                         input logic [ADDR_WIDTH-1:0] rem,
                                         input logic [DIM_WIDTH:0]    rl);
    return (rl == ONE_ROW) && (rem <= span_limit(a));
  endfunction

  always_comb begin
    win_addr      = frame_base_addr
                  + ADDR_WIDTH'(r0) * ADDR_WIDTH'(frame_stride_bytes)
                  + ADDR_WIDTH'(c0) * ADDR_WIDTH'(bytes_per_pixel);
    win_bytes     = ADDR_WIDTH'(c1 - c0) * ADDR_WIDTH'(bytes_per_pixel);
    win_rows      = r1 - r0;
    step_in_row   = remain > ADDR_WIDTH'(bus.burst_len);
    nxt_row_addr  = row_addr + ADDR_WIDTH'(frame_stride_bytes);
    nxt_addr      = step_in_row ? bus.burst_addr + ADDR_WIDTH'(bus.burst_len) : nxt_row_addr;
    nxt_remain    = step_in_row ? remain - ADDR_WIDTH'(bus.burst_len) : row_bytes;
    nxt_rows_left = step_in_row ? rows_left : rows_left - ONE_ROW;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.req_ready   <= 1'b1;
      bus.burst_valid <= 1'b0;
      bus.burst_addr  <= '0;
      bus.burst_len   <= '0;
      bus.burst_last  <= 1'b0;
      busy            <= 1'b0;
      row_start_q     <= '0;
      col_start_q     <= '0;
      rows_q          <= '0;
      cols_q          <= '0;
      halo_q          <= '0;
      is_ref_q        <= 1'b0;
      row_addr        <= '0;
      row_bytes       <= '0;
      remain          <= '0;
      rows_left       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            row_start_q   <= bus.req_row_start;
            col_start_q   <= bus.req_col_start;
            rows_q        <= bus.req_rows;
            cols_q        <= bus.req_cols;
            halo_q        <= bus.req_halo;
            is_ref_q      <= bus.req_is_reference;
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= SETUP;
          end
        end
        SETUP: begin
          if (win_empty) begin
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            row_addr        <= win_addr;
            row_bytes       <= win_bytes;
            remain          <= win_bytes;
            rows_left       <= win_rows;
            bus.burst_addr  <= win_addr;
            bus.burst_len   <= burst_len_of(win_addr, win_bytes);
            bus.burst_last  <= burst_last_of(win_addr, win_bytes, win_rows);
            bus.burst_valid <= 1'b1;
            state           <= EMIT;
          end
        end
        EMIT: begin
          if (bus.burst_ready) begin
            if (bus.burst_last) begin
              bus.burst_valid <= 1'b0;
              bus.burst_last  <= 1'b0;
              bus.req_ready   <= 1'b1;
              busy            <= 1'b0;
              state           <= IDLE;
            end else begin
              if (!step_in_row) row_addr <= nxt_row_addr;
              remain         <= nxt_remain;
              rows_left      <= nxt_rows_left;
              bus.burst_addr <= nxt_addr;
              bus.burst_len  <= burst_len_of(nxt_addr, nxt_remain);
              bus.burst_last <= burst_last_of(nxt_addr, nxt_remain, nxt_rows_left);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_burst_gen.sv
// tb/tb_tile_burst_gen.sv - self-checking bench for tile_burst_gen
module tb_tile_burst_gen;

  localparam int MAXB = 256;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    logic        last;
  } burst_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] frame_base_addr = '0;
  logic [15:0] frame_stride_bytes = '0;
  logic [15:0] bytes_per_pixel = '0;
  logic [15:0] frame_width = '0;
  logic [15:0] frame_height = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  burst_t exp_q[$];
  burst_t log_q[$];

  logic        holding = 1'b0;
  logic [31:0] held_addr;
  logic [15:0] held_len;
  logic        held_last;

  tile_burst_gen_if #(.ADDR_WIDTH(32), .DIM_WIDTH(16), .LEN_WIDTH(16)) bus ();

  tile_burst_gen dut (
    .clk                (clk),
    .rst                (rst),
    .frame_base_addr    (frame_base_addr),
    .frame_stride_bytes (frame_stride_bytes),
    .bytes_per_pixel    (bytes_per_pixel),
    .frame_width        (frame_width),
    .frame_height       (frame_height),
    .bus                (bus),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: walk the clamped window row by row, chopping each row.
  task automatic build_model(input int row, input int col, input int rows, input int cols,
                             input int halo, input bit is_ref);
    int h, r0, r1, c0, c1;
    longint a, bytes, cap, len;
    burst_t b;
    h  = is_ref ? halo : 0;
    r0 = (row >= h) ? row - h : 0;
    c0 = (col >= h) ? col - h : 0;
    r1 = (row + rows + h < int'(frame_height)) ? row + rows + h : int'(frame_height);
    c1 = (col + cols + h < int'(frame_width)) ? col + cols + h : int'(frame_width);
    exp_q.delete();
    if (r1 > r0 && c1 > c0) begin
      for (int r = r0; r < r1; r++) begin
        a     = longint'(frame_base_addr) + longint'(r) * longint'(frame_stride_bytes)
              + longint'(c0) * longint'(bytes_per_pixel);
        bytes = longint'(c1 - c0) * longint'(bytes_per_pixel);
        while (bytes > 0) begin
          cap = MAXB;
`ifdef BURST_ALIGN_SPLIT_EN
          cap = MAXB - (a % MAXB);
`endif
          len    = (bytes < cap) ? bytes : cap;
          b.addr = a[31:0];
          b.len  = len[15:0];
          b.last = (r == r1 - 1) && (bytes == len);
          exp_q.push_back(b);
          a     += len;
          bytes -= len;
        end
      end
    end
  endtask

  // Compare process: every presented descriptor against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else if (bus.burst_valid) begin
      if (holding) begin
        check("hold_addr", 64'(bus.burst_addr), 64'(held_addr));
        check("hold_len", 64'(bus.burst_len), 64'(held_len));
        check("hold_last", 64'(bus.burst_last), 64'(held_last));
      end
      check("burst_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        check("burst_addr", 64'(bus.burst_addr), 64'(exp_q[0].addr));
        check("burst_len", 64'(bus.burst_len), 64'(exp_q[0].len));
        check("burst_last", 64'(bus.burst_last), 64'(exp_q[0].last));
      end
      if (bus.burst_ready) begin
        log_q.push_back('{addr: bus.burst_addr, len: bus.burst_len, last: bus.burst_last});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        holding = 1'b0;
      end else begin
        holding   = 1'b1;
        held_addr = bus.burst_addr;
        held_len  = bus.burst_len;
        held_last = bus.burst_last;
      end
    end else begin
      if (holding) check("valid_held", 64'(bus.burst_valid), 64'(1));
      holding = 1'b0;
    end
  end

  task automatic start_req(input int row, input int col, input int rows, input int cols,
                           input int halo, input bit is_ref, input bit ready);
    build_model(row, col, rows, cols, halo, is_ref);
    log_q.delete();
    @(posedge clk); #1;
    bus.burst_ready      = ready;
    bus.req_row_start    = 16'(row);
    bus.req_col_start    = 16'(col);
    bus.req_rows         = 16'(rows);
    bus.req_cols         = 16'(cols);
    bus.req_halo         = 16'(halo);
    bus.req_is_reference = is_ref;
    bus.req_valid        = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic run_tile(input int row, input int col, input int rows, input int cols,
                          input int halo, input bit is_ref, input int bp);
    int n_exp;
    int cyc;
    start_req(row, col, rows, cols, halo, is_ref, bp == 0);
    n_exp = exp_q.size();
    @(negedge clk);
    check("setup_busy", 64'(busy), 64'(1));
    check("setup_valid", 64'(bus.burst_valid), 64'(0));
    check("setup_req_ready", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    check("first_valid_n2", 64'(bus.burst_valid), 64'(n_exp > 0));
    if (n_exp == 0) check("empty_busy_n2", 64'(busy), 64'(0));
    if (bp > 0) begin
      repeat (bp) @(posedge clk);
      #1 bus.burst_ready = 1'b1;
    end
    cyc = 0;
    while ((busy || exp_q.size() != 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("tile_done", 64'(busy || exp_q.size() != 0), 64'(0));
    check("burst_count", 64'(log_q.size()), 64'(n_exp));
    check("idle_req_ready", 64'(bus.req_ready), 64'(1));
  endtask

  task automatic check_log(input int i, input logic [31:0] addr, input logic [15:0] len,
                           input logic last);
    check("log_present", 64'(log_q.size() > i), 64'(1));
    if (log_q.size() > i) begin
      check("lit_addr", 64'(log_q[i].addr), 64'(addr));
      check("lit_len", 64'(log_q[i].len), 64'(len));
      check("lit_last", 64'(log_q[i].last), 64'(last));
    end
  endtask

  task automatic cfg(input logic [31:0] base, input int stride, input int bpp,
                     input int w, input int h);
    frame_base_addr    = base;
    frame_stride_bytes = 16'(stride);
    bytes_per_pixel    = 16'(bpp);
    frame_width        = 16'(w);
    frame_height       = 16'(h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.req_valid        = 1'b0;
    bus.req_row_start    = '0;
    bus.req_col_start    = '0;
    bus.req_rows         = '0;
    bus.req_cols         = '0;
    bus.req_halo         = '0;
    bus.req_is_reference = 1'b0;
    bus.burst_ready      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    check("rst_valid", 64'(bus.burst_valid), 64'(0));
    check("rst_addr", 64'(bus.burst_addr), 64'(0));
    check("rst_len", 64'(bus.burst_len), 64'(0));
    check("rst_last", 64'(bus.burst_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Motion tile
    cfg(32'h1000, 1920, 2, 960, 540);
    run_tile(4, 8, 2, 16, 7, 1'b0, 0);
    check_log(0, 32'h2E10, 16'd32, 1'b0);
    check_log(1, 32'h3590, 16'd32, 1'b1);

    // Reference, top-left clamp
    cfg(32'h0, 64, 1, 64, 64);
    run_tile(0, 0, 4, 4, 2, 1'b1, 0);
    check_log(0, 32'd0, 16'd6, 1'b0);
    check_log(3, 32'd192, 16'd6, 1'b0);
    check_log(5, 32'd320, 16'd6, 1'b1);

    // Reference, bottom-right clamp
    run_tile(62, 60, 4, 4, 2, 1'b1, 0);
    check_log(0, 32'd3898, 16'd6, 1'b0);
    check_log(3, 32'd4090, 16'd6, 1'b1);

    // Row split
`ifdef BURST_ALIGN_SPLIT_EN
    cfg(32'h80, 512, 4, 128, 4);
    run_tile(0, 0, 1, 100, 0, 1'b0, 0);
    check_log(0, 32'h80, 16'd128, 1'b0);
    check_log(1, 32'h100, 16'd256, 1'b0);
    check_log(2, 32'h200, 16'd16, 1'b1);
`else
    cfg(32'h0, 512, 4, 128, 4);
    run_tile(0, 0, 1, 100, 0, 1'b0, 0);
    check_log(0, 32'h0, 16'd256, 1'b0);
    check_log(1, 32'h100, 16'd144, 1'b1);
`endif

    // Backpressure on the first burst of the motion tile
    cfg(32'h1000, 1920, 2, 960, 540);
    run_tile(4, 8, 2, 16, 0, 1'b0, 5);
    check_log(0, 32'h2E10, 16'd32, 1'b0);
    check_log(1, 32'h3590, 16'd32, 1'b1);

    // Empty tile
    run_tile(4, 8, 0, 16, 0, 1'b0, 0);

    // Reset while the second burst of the top-left reference tile is up
    cfg(32'h0, 64, 1, 64, 64);
    start_req(0, 0, 4, 4, 2, 1'b1, 1'b1);
    cyc = 0;
    while (log_q.size() < 2 && cyc < 50) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("reached_burst2", 64'(log_q.size()), 64'(2));
    check("burst2_valid", 64'(bus.burst_valid), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(bus.burst_valid), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    cyc = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.burst_valid) cyc++;
    end
    check("post_rst_no_burst", 64'(cyc), 64'(0));
    check("post_rst_req_ready", 64'(bus.req_ready), 64'(1));
    check("post_rst_busy", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
